alu_seq: RTL and testbench
==========================

// Module: alu_seq
// PURPOSE
//  Parametrised, registered successor to the 19-bit combinational ALU. Adds a start/busy/done
//  handshake, registered flags, iterative multiply/divide/remainder and a divide-by-zero flag.
//  Sits between register-file read and write-back in the processor datapath.
//  The control FSM stalls issue while busy=1.
// PARAMETERS
//  WIDTH   19   operand/result width in bits (>=4)
//  CNT_W   5    iteration counter width, $clog2(WIDTH+1)
// PORTS
//  clk        in   1      system clock, rising edge
//  rst        in   1      synchronous, active-high reset
//  start      in   1      request; sampled only when busy=0
//  op         in   4      opcode (see alu_pkg)
//  a          in   WIDTH  operand 1 (R2)
//  b          in   WIDTH  operand 2 (R3)
//  busy       out  1      iterative op in progress
//  done       out  1      one-cycle pulse: result/flags updated this cycle
//  result     out  WIDTH  registered result (R1)
//  zero       out  1      result==0
//  carry      out  1      ADD carry-out / SUB borrow (a<b unsigned)
//  overflow   out  1      signed ADD/SUB overflow; MUL: nonzero upper product bits
//  div_zero   out  1      DIV/REM issued with b==0
// BEHAVIOUR
//  - One clock. Reset is synchronous and active-high. Reset sets every output to 0 and the FSM to IDLE.
//    Reset wins over start. Reset mid-operation aborts the op with no done pulse.
//  - Opcodes: 0 ADD, 1 SUB, 2 MUL (low WIDTH bits), 3 DIV (unsigned quotient), 4 REM,
//    5 SHL a<<b[CNT_W-1:0], 6 AND, 7 OR, 8 XOR, 9 NOT a, 10-15 illegal -> result 0.
//  - Accept: the op is accepted when start=1 && busy=0 at a rising edge.
//    a, b and op are captured at accept; later changes on them are ignored.
//  - Single-cycle ops (all except MUL/DIV/REM, and DIV/REM with b==0):
//    result and flags register at the accept edge; done=1 for the following cycle; busy stays 0.
//    Back-to-back starts give one done per cycle.
//  - Iterative ops (MUL shift-add, DIV/REM restoring), one bit per cycle:
//    busy=1 for WIDTH cycles starting the cycle after accept.
//    Result and flags register WIDTH+1 edges after accept; done=1 that cycle; busy=0 that same cycle.
//    start is ignored while busy=1 and is never queued.
//  - FSM: IDLE --accept iterative--> RUN (counter WIDTH-1..0) --count==0--> IDLE, with done pulse.
//  - Flags update only with done; they hold otherwise. zero is always computed from the new result.
//    carry and overflow are 0 for every op other than ADD/SUB/MUL as defined above.
//    div_zero=1 only for DIV/REM with b==0, otherwise 0.
//  - Divide by zero: single-cycle. DIV result = all ones; REM result = a.
//  - Widths: ADD/SUB use a WIDTH+1 internal sum. MUL uses a 2*WIDTH product accumulator.
//    SHL with shift amount >= WIDTH gives 0.
//  - result holds its value between done pulses. done never asserts without a prior accept.
// STRUCTURE
//  - alu_pkg: opcode localparams (OP_ADD..OP_NOT) and FSM state encodings; shared with decoder.
//  - Sub-module alu_iter_muldiv: shift-add multiplier and restoring divider.
//    Ports: clk, rst, go, is_div, a, b -> prod_lo, prod_hi_nz, quot, rem, fin.
//  - Top level: opcode decode, single-cycle datapath, flag logic, handshake FSM.
// TESTING (WIDTH=19)
//  1. ADD 0x7FFFF+0x00001 -> result 0, zero=1, carry=1, overflow=0, done 1 cycle after accept.
//     ADD 0x3FFFF+1 -> 0x40000, overflow=1, carry=0.
//  2. SUB 5-7 -> 0x7FFFE, carry(borrow)=1, overflow=0.
//     SUB 0x40000-1 -> 0x3FFFF, overflow=1.
//  3. MUL 300*400 -> busy 19 cycles, done 20 edges after accept, result 120000, overflow=0.
//     MUL 1000*1000 -> result 475712, overflow=1.
//  4. DIV 100/7 -> 14; REM 100/7 -> 2; each has 20-cycle latency, div_zero=0.
//     DIV 9/0 -> 0x7FFFF, div_zero=1, done after 1 cycle, busy never high.
//  5. start held high during MUL with a different op -> ignored; exactly one done; MUL result correct.
//     Back-to-back AND/OR/XOR starts -> three consecutive done pulses, each result correct.
//  6. rst asserted 5 cycles into MUL -> next cycle busy=0, done=0, result=0, all flags 0.
//     A new ADD issued afterwards completes normally.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: opcodes, control states and
// the issue-classification helper used by the decoder.
package alu_pkg;

  // Opcode encodings (4-bit op field); 10..15 are illegal and yield 0.
  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_MUL = 4'd2;
  localparam logic [3:0] OP_DIV = 4'd3;
  localparam logic [3:0] OP_REM = 4'd4;
  localparam logic [3:0] OP_SHL = 4'd5;
  localparam logic [3:0] OP_AND = 4'd6;
  localparam logic [3:0] OP_OR  = 4'd7;
  localparam logic [3:0] OP_XOR = 4'd8;
  localparam logic [3:0] OP_NOT = 4'd9;

  // Handshake controller states.
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // An op runs iteratively when it is MUL, or DIV/REM with a nonzero divisor.
  // Divide-by-zero is resolved in a single cycle.
  function automatic logic op_is_iter(input logic [3:0] op, input logic b_nz);
    logic r;
    case (op)
      OP_MUL:         r = 1'b1;
      OP_DIV, OP_REM: r = b_nz;
      default:        r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/alu_iter_muldiv.sv
// Iterative multiply / divide engine, one bit per clock.
// MUL: shift-add, product held as {hi_r, lo_r}, multiplicand in opnd_r.
// DIV/REM: restoring division, partial remainder in hi_r, dividend shifting
// out of lo_r while quotient bits shift in, divisor in opnd_r.
// Outputs are the combinational result of the step currently being taken,
// so on the cycle fin=1 they already hold the final answer and the parent
// can register them on the same edge.
module alu_iter_muldiv
  import alu_pkg::*;
#(
  parameter int WIDTH = 19,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             go,
  input  logic             is_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] prod_lo,
  output logic             prod_hi_nz,
  output logic [WIDTH-1:0] quot,
  output logic [WIDTH-1:0] rem,
  output logic             fin
);

  logic             run_r;
  logic             div_r;
  logic [CNT_W-1:0] cnt_r;
  logic [WIDTH-1:0] hi_r;
  logic [WIDTH-1:0] lo_r;
  logic [WIDTH-1:0] opnd_r;

  logic [WIDTH:0]   msum_s;
  logic [WIDTH:0]   trial_s;
  logic [WIDTH:0]   tdiff_s;
  logic [WIDTH-1:0] nxt_hi_s;
  logic [WIDTH-1:0] nxt_lo_s;

  // One iteration step for whichever operation is loaded.
  always_comb begin
    nxt_hi_s = hi_r;
    nxt_lo_s = lo_r;
    msum_s   = {1'b0, hi_r} + (lo_r[0] ? {1'b0, opnd_r} : {(WIDTH+1){1'b0}});
    trial_s  = {hi_r, lo_r[WIDTH-1]};
    tdiff_s  = trial_s - {1'b0, opnd_r};
    if (div_r) begin
      // The partial remainder stays below the divisor, so bit WIDTH of the
      // difference is a clean borrow: clear means trial >= divisor.
      if (!tdiff_s[WIDTH]) begin
        nxt_hi_s = tdiff_s[WIDTH-1:0];
        nxt_lo_s = {lo_r[WIDTH-2:0], 1'b1};
      end else begin
        nxt_hi_s = trial_s[WIDTH-1:0];
        nxt_lo_s = {lo_r[WIDTH-2:0], 1'b0};
      end
    end else begin
      nxt_hi_s = msum_s[WIDTH:1];
      nxt_lo_s = {msum_s[0], lo_r[WIDTH-1:1]};
    end
  end

  // Result taps: valid on the cycle fin is high.
  always_comb begin
    prod_lo    = nxt_lo_s;
    prod_hi_nz = |nxt_hi_s;
    quot       = nxt_lo_s;
    rem        = nxt_hi_s;
    fin        = run_r && (cnt_r == {CNT_W{1'b0}});
  end

  // Operand load on go, then WIDTH steps counting cnt_r down to zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      run_r  <= 1'b0;
      div_r  <= 1'b0;
      cnt_r  <= {CNT_W{1'b0}};
      hi_r   <= {WIDTH{1'b0}};
      lo_r   <= {WIDTH{1'b0}};
      opnd_r <= {WIDTH{1'b0}};
    end else if (go) begin
      run_r  <= 1'b1;
      div_r  <= is_div;
      cnt_r  <= CNT_W'(WIDTH - 1);
      hi_r   <= {WIDTH{1'b0}};
      lo_r   <= is_div ? a : b;
      opnd_r <= is_div ? b : a;
    end else if (run_r) begin
      hi_r <= nxt_hi_s;
      lo_r <= nxt_lo_s;
      if (cnt_r == {CNT_W{1'b0}}) begin
        run_r <= 1'b0;
      end else begin
        cnt_r <= cnt_r - CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Registered ALU with start/busy/done handshake. Single-cycle ops complete
// at the accept edge; MUL and DIV/REM (nonzero divisor) run WIDTH cycles in
// the iterative engine. Result and flags change only when done is raised.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 19,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             carry,
  output logic             overflow,
  output logic             div_zero
);

  state_t           state_r;
  state_t           state_nxt_s;
  logic             busy_r;
  logic             done_r;
  logic [WIDTH-1:0] result_r;
  logic             zero_r;
  logic             carry_r;
  logic             overflow_r;
  logic             div_zero_r;
  logic [3:0]       op_r;

  logic [WIDTH:0]   sum_s;
  logic [WIDTH:0]   dif_s;
  logic [CNT_W-1:0] shamt_s;
  logic [WIDTH-1:0] sc_res_s;
  logic             sc_carry_s;
  logic             sc_ovf_s;
  logic             sc_dz_s;

  logic             iter_s;
  logic             is_div_s;
  logic             go_s;
  logic             upd_s;
  logic [WIDTH-1:0] it_res_s;
  logic             it_ovf_s;
  logic [WIDTH-1:0] res_nxt_s;
  logic             zero_nxt_s;
  logic             carry_nxt_s;
  logic             ovf_nxt_s;
  logic             dz_nxt_s;

  logic [WIDTH-1:0] prod_lo_s;
  logic             prod_hi_nz_s;
  logic [WIDTH-1:0] quot_s;
  logic [WIDTH-1:0] rem_s;
  logic             fin_s;

  alu_iter_muldiv #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_iter (
    .clk        (clk),
    .rst        (rst),
    .go         (go_s),
    .is_div     (is_div_s),
    .a          (a),
    .b          (b),
    .prod_lo    (prod_lo_s),
    .prod_hi_nz (prod_hi_nz_s),
    .quot       (quot_s),
    .rem        (rem_s),
    .fin        (fin_s)
  );

  // Decode: classify the incoming op and pick the engine mode.
  always_comb begin
    iter_s   = op_is_iter(op, b != {WIDTH{1'b0}});
    is_div_s = (op == OP_DIV) || (op == OP_REM);
  end

  // Single-cycle datapath on the live operands (captured at the accept edge).
  always_comb begin
    sum_s      = {1'b0, a} + {1'b0, b};
    dif_s      = {1'b0, a} - {1'b0, b};
    shamt_s    = b[CNT_W-1:0];
    sc_res_s   = {WIDTH{1'b0}};
    sc_carry_s = 1'b0;
    sc_ovf_s   = 1'b0;
    sc_dz_s    = 1'b0;
    case (op)
      OP_ADD: begin
        sc_res_s   = sum_s[WIDTH-1:0];
        sc_carry_s = sum_s[WIDTH];
        sc_ovf_s   = (a[WIDTH-1] == b[WIDTH-1]) && (sum_s[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        sc_res_s   = dif_s[WIDTH-1:0];
        sc_carry_s = dif_s[WIDTH];
        sc_ovf_s   = (a[WIDTH-1] != b[WIDTH-1]) && (dif_s[WIDTH-1] != a[WIDTH-1]);
      end
      // DIV/REM only take this path when the divisor is zero.
      OP_DIV: begin
        sc_res_s = {WIDTH{1'b1}};
        sc_dz_s  = 1'b1;
      end
      OP_REM: begin
        sc_res_s = a;
        sc_dz_s  = 1'b1;
      end
      OP_SHL: begin
        if (int'(shamt_s) >= WIDTH) begin
          sc_res_s = {WIDTH{1'b0}};
        end else begin
          sc_res_s = a << shamt_s;
        end
      end
      OP_AND:  sc_res_s = a & b;
      OP_OR:   sc_res_s = a | b;
      OP_XOR:  sc_res_s = a ^ b;
      OP_NOT:  sc_res_s = ~a;
      default: sc_res_s = {WIDTH{1'b0}};
    endcase
  end

  // Iterative result selection by the op captured at accept.
  always_comb begin
    it_res_s = {WIDTH{1'b0}};
    it_ovf_s = 1'b0;
    case (op_r)
      OP_MUL: begin
        it_res_s = prod_lo_s;
        it_ovf_s = prod_hi_nz_s;
      end
      OP_DIV:  it_res_s = quot_s;
      OP_REM:  it_res_s = rem_s;
      default: it_res_s = {WIDTH{1'b0}};
    endcase
  end

  // Handshake FSM: next state, engine launch and next result/flags.
  always_comb begin
    state_nxt_s = state_r;
    go_s        = 1'b0;
    upd_s       = 1'b0;
    res_nxt_s   = result_r;
    carry_nxt_s = carry_r;
    ovf_nxt_s   = overflow_r;
    dz_nxt_s    = div_zero_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          if (iter_s) begin
            go_s        = 1'b1;
            state_nxt_s = ST_RUN;
          end else begin
            upd_s       = 1'b1;
            res_nxt_s   = sc_res_s;
            carry_nxt_s = sc_carry_s;
            ovf_nxt_s   = sc_ovf_s;
            dz_nxt_s    = sc_dz_s;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (fin_s) begin
          state_nxt_s = ST_IDLE;
          upd_s       = 1'b1;
          res_nxt_s   = it_res_s;
          carry_nxt_s = 1'b0;
          ovf_nxt_s   = it_ovf_s;
          dz_nxt_s    = 1'b0;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
    if (upd_s) begin
      zero_nxt_s = (res_nxt_s == {WIDTH{1'b0}});
    end else begin
      zero_nxt_s = zero_r;
    end
  end

  // State, handshake and result/flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      result_r   <= {WIDTH{1'b0}};
      zero_r     <= 1'b0;
      carry_r    <= 1'b0;
      overflow_r <= 1'b0;
      div_zero_r <= 1'b0;
      op_r       <= 4'd0;
    end else begin
      state_r    <= state_nxt_s;
      busy_r     <= (state_nxt_s == ST_RUN);
      done_r     <= upd_s;
      result_r   <= res_nxt_s;
      zero_r     <= zero_nxt_s;
      carry_r    <= carry_nxt_s;
      overflow_r <= ovf_nxt_s;
      div_zero_r <= dz_nxt_s;
      if (go_s) begin
        op_r <= op;
      end
    end
  end

  // Output drive straight from registers.
  always_comb begin
    busy     = busy_r;
    done     = done_r;
    result   = result_r;
    zero     = zero_r;
    carry    = carry_r;
    overflow = overflow_r;
    div_zero = div_zero_r;
  end

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq (WIDTH=19): expectations are computed by a
// behavioural model when an op is accepted and compared when done pulses.
module tb_alu_seq;
  import alu_pkg::*;

  localparam int W  = 19;
  localparam int CW = 5;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [3:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         zero;
  logic         carry;
  logic         overflow;
  logic         div_zero;

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .op       (op),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .zero     (zero),
    .carry    (carry),
    .overflow (overflow),
    .div_zero (div_zero)
  );

  typedef struct {
    logic [W-1:0] res;
    logic         c;
    logic         v;
    logic         dz;
    int           lat;
    int           acc;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp    = 0;
  int   n_err    = 0;
  int   cyc      = 0;
  int   busy_cnt = 0;
  int   done_cnt = 0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_cmp++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, expv, $time);
    end
  endtask

  function automatic longint sval(input logic [W-1:0] x);
    return x[W-1] ? (longint'(x) - (longint'(1) <<< W)) : longint'(x);
  endfunction

  function automatic exp_t model(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t   e;
    longint ux, uy, s, p;
    longint smax, smin;
    ux = longint'(x);
    uy = longint'(y);
    smax = (longint'(1) <<< (W-1)) - 1;
    smin = -(longint'(1) <<< (W-1));
    e.res = '0; e.c = 1'b0; e.v = 1'b0; e.dz = 1'b0; e.lat = 1; e.acc = 0;
    case (o)
      OP_ADD: begin
        s = sval(x) + sval(y);
        e.res = W'(ux + uy);
        e.c = ((ux + uy) >>> W) != 0;
        e.v = (s > smax) || (s < smin);
      end
      OP_SUB: begin
        s = sval(x) - sval(y);
        e.res = W'(ux - uy);
        e.c = ux < uy;
        e.v = (s > smax) || (s < smin);
      end
      OP_MUL: begin
        p = ux * uy;
        e.res = W'(p);
        e.v = (p >>> W) != 0;
        e.lat = W + 1;
      end
      OP_DIV: begin
        if (uy == 0) begin e.res = '1; e.dz = 1'b1; end
        else begin e.res = W'(ux / uy); e.lat = W + 1; end
      end
      OP_REM: begin
        if (uy == 0) begin e.res = x; e.dz = 1'b1; end
        else begin e.res = W'(ux % uy); e.lat = W + 1; end
      end
      OP_SHL:  e.res = (int'(y[4:0]) >= W) ? '0 : W'(ux << y[4:0]);
      OP_AND:  e.res = x & y;
      OP_OR:   e.res = x | y;
      OP_XOR:  e.res = x ^ y;
      OP_NOT:  e.res = ~x;
      default: e.res = '0;
    endcase
    return e;
  endfunction

  // Output monitor: pops the scoreboard on each done pulse.
  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (busy) busy_cnt++;
      if (done) done_cnt++;
      if (sb_q.size() == 0) begin
        check_val("unexpected_done", done, 1'b0);
      end else if (done) begin
        e = sb_q.pop_front();
        check_val("result",       result,   e.res);
        check_val("zero",         zero,     e.res == '0);
        check_val("carry",        carry,    e.c);
        check_val("overflow",     overflow, e.v);
        check_val("div_zero",     div_zero, e.dz);
        check_val("latency",      cyc - e.acc, e.lat);
        check_val("busy_at_done", busy,     1'b0);
      end
    end
  endtask

  // Present an op at a negedge; record the expectation once it is accepted.
  task automatic drive(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t e;
    @(negedge clk);
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clk);
    e = model(o, x, y);
    e.acc = cyc;
    sb_q.push_back(e);
  endtask

  task automatic idle();
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && sb_q.size() != 0; i++) @(negedge clk);
    check_val("drain", sb_q.size(), 0);
    sb_q.delete();
    @(negedge clk);
  endtask

  task automatic run(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    drive(o, x, y);
    idle();
    drain();
  endtask

  initial begin
    int b0;
    int d0;
    logic [3:0]   ro;
    logic [W-1:0] rx, ry;
    rst = 1'b1; start = 1'b0; op = 4'd0; a = '0; b = '0;
    fork monitor(); join_none
    repeat (3) @(negedge clk);
    check_val("rst_busy", busy, 1'b0);
    check_val("rst_done", done, 1'b0);
    check_val("rst_result", result, '0);
    check_val("rst_zero", zero, 1'b0);
    check_val("rst_carry", carry, 1'b0);
    check_val("rst_overflow", overflow, 1'b0);
    check_val("rst_div_zero", div_zero, 1'b0);
    rst = 1'b0;

    run(OP_ADD, 19'h7FFFF, 19'h00001);
    run(OP_ADD, 19'h3FFFF, 19'h00001);
    run(OP_SUB, 19'd5, 19'd7);
    run(OP_SUB, 19'h40000, 19'h00001);

    b0 = busy_cnt;
    run(OP_MUL, 19'd300, 19'd400);
    check_val("mul_busy_cycles", busy_cnt - b0, W);
    run(OP_MUL, 19'd1000, 19'd1000);
    run(OP_MUL, 19'h7FFFF, 19'h7FFFF);
    run(OP_DIV, 19'd100, 19'd7);
    run(OP_REM, 19'd100, 19'd7);
    run(OP_DIV, 19'h7FFFF, 19'd1);
    b0 = busy_cnt;
    run(OP_DIV, 19'd9, 19'd0);
    run(OP_REM, 19'd9, 19'd0);
    check_val("divz_busy_cycles", busy_cnt - b0, 0);
    run(OP_SHL, 19'd1, 19'd18);
    run(OP_SHL, 19'd1, 19'd19);
    run(OP_SHL, 19'h12345, 19'd31);
    run(OP_NOT, 19'h0F0F0, 19'd0);
    run(4'd12, 19'h12345, 19'h54321);

    // start held high with a different op while MUL is running
    d0 = done_cnt;
    drive(OP_MUL, 19'd123, 19'd456);
    @(negedge clk);
    op = OP_AND; a = 19'h7FFFF; b = 19'h00F0F;
    repeat (10) @(negedge clk);
    start = 1'b0;
    drain();
    check_val("held_start_dones", done_cnt - d0, 1);

    // back-to-back single-cycle ops
    d0 = done_cnt;
    drive(OP_AND, 19'h5A5A5, 19'h0FF0F);
    drive(OP_OR,  19'h50505, 19'h0A0A0);
    drive(OP_XOR, 19'h7FFFF, 19'h12345);
    idle();
    drain();
    check_val("b2b_dones", done_cnt - d0, 3);

    // reset five cycles into a MUL
    run(OP_MUL, 19'd1000, 19'd1000);
    drive(OP_MUL, 19'd300, 19'd400);
    idle();
    repeat (4) @(negedge clk);
    rst = 1'b1;
    sb_q.delete();
    @(negedge clk);
    check_val("abort_busy", busy, 1'b0);
    check_val("abort_done", done, 1'b0);
    check_val("abort_result", result, '0);
    check_val("abort_zero", zero, 1'b0);
    check_val("abort_carry", carry, 1'b0);
    check_val("abort_overflow", overflow, 1'b0);
    check_val("abort_div_zero", div_zero, 1'b0);
    rst = 1'b0;
    repeat (25) @(negedge clk);
    run(OP_ADD, 19'd1234, 19'd4321);

    // random mix
    for (int k = 0; k < 24; k++) begin
      ro = 4'($urandom_range(0, 15));
      rx = W'($urandom);
      ry = ($urandom_range(0, 3) == 0) ? '0 : W'($urandom);
      if (ro == OP_SHL) ry = W'($urandom_range(0, 31));
      run(ro, rx, ry);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
